// File: rtl/ff_chk_pkg.sv
// Shared types and constants for the flip-flop response checker.
package ff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNSYNC = 2'd1,
        ST_TRACK  = 2'd2
    } chk_state_t;

    localparam logic MODE_JK   = 1'b0;
    localparam logic MODE_SR   = 1'b1;
    localparam int   CNT_W_DEF = 8;

endpackage

// File: rtl/ff_response_checker_if.sv
// Bundle of stimulus observation and checker status signals.
interface ff_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             mode;
    logic             check_en;
    logic             a;
    logic             b;
    logic             q_obs;
    logic             qn_obs;
    logic             q_exp;
    logic             exp_valid;
    logic             mismatch;
    logic             comp_err;
    logic             illegal;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] chk_count;

    modport master (
        output mode, check_en, a, b, q_obs, qn_obs,
        input  q_exp, exp_valid, mismatch, comp_err, illegal, err_sticky, err_count, chk_count
    );

    modport slave (
        input  mode, check_en, a, b, q_obs, qn_obs,
        output q_exp, exp_valid, mismatch, comp_err, illegal, err_sticky, err_count, chk_count
    );
endinterface

// File: rtl/ff_ref_model.sv
// Combinational next-state model of a JK or SR flip-flop.
module ff_ref_model
    import ff_chk_pkg::*;
(
    input  logic mode,
    input  logic a,
    input  logic b,
    input  logic q_cur,
    output logic q_next,
    output logic defined,
    output logic illegal
);

    always_comb begin
        q_next  = q_cur;
        illegal = 1'b0;
        // Only 01/10 fix the next state independently of the current one
        defined = (a != b);
        case ({a, b})
            2'b00: q_next = q_cur;
            2'b01: q_next = 1'b0;
            2'b10: q_next = 1'b1;
            2'b11: begin
                q_next  = (mode == MODE_JK) ? ~q_cur : q_cur;
                illegal = (mode == MODE_SR);
            end
        endcase
    end

endmodule

// File: rtl/ff_response_checker.sv
// Cycle-accurate response checker for an SR/JK flip-flop with sticky status and saturating counters.
// Optional FF_CHK_LOCK_ON_OBS_EN: resynchronise from complementary Q/Qn while unsynchronised.
module ff_response_checker
    import ff_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ff_response_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_t       state_reg;
    logic             q_exp_reg;
    logic             exp_valid_reg;
    logic             mismatch_reg;
    logic             comp_err_reg;
    logic             illegal_reg;
    logic             err_sticky_reg;
    logic             track_mode_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [CNT_W-1:0] chk_count_reg;

    logic rm_q_cur;
    logic rm_q_next;
    logic rm_defined;
    logic rm_illegal;
    logic lock_ok;
    logic cmp_mis;
    logic cmp_ce;

`ifdef FF_CHK_LOCK_ON_OBS_EN
    // Adopt the observed Q and apply this edge's inputs so the model lands where the DUT does
    assign rm_q_cur = (state_reg == ST_UNSYNC) ? bus.q_obs : q_exp_reg;
    assign lock_ok  = (bus.q_obs != bus.qn_obs) && !rm_illegal;
`else
    assign rm_q_cur = q_exp_reg;
    assign lock_ok  = 1'b0;
`endif

    ff_ref_model u_ref (
        .mode    (bus.mode),
        .a       (bus.a),
        .b       (bus.b),
        .q_cur   (rm_q_cur),
        .q_next  (rm_q_next),
        .defined (rm_defined),
        .illegal (rm_illegal)
    );

    assign cmp_mis = (bus.q_obs != q_exp_reg);
    assign cmp_ce  = (bus.qn_obs == bus.q_obs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            q_exp_reg      <= 1'b0;
            exp_valid_reg  <= 1'b0;
            mismatch_reg   <= 1'b0;
            comp_err_reg   <= 1'b0;
            illegal_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
            track_mode_reg <= MODE_JK;
            err_count_reg  <= '0;
            chk_count_reg  <= '0;
        end else begin
            mismatch_reg <= 1'b0;
            comp_err_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            if (!bus.check_en) begin
                state_reg     <= ST_IDLE;
                exp_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: state_reg <= ST_UNSYNC;
                    ST_UNSYNC: begin
                        if (rm_defined || lock_ok) begin
                            q_exp_reg      <= rm_q_next;
                            track_mode_reg <= bus.mode;
                            state_reg      <= ST_TRACK;
                            exp_valid_reg  <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (bus.mode != track_mode_reg) begin
                            state_reg     <= ST_UNSYNC;
                            exp_valid_reg <= 1'b0;
                        end else begin
                            // Compare against the pre-update model, then advance it
                            if (!(&chk_count_reg)) chk_count_reg <= chk_count_reg + CNT_ONE;
                            mismatch_reg <= cmp_mis;
                            comp_err_reg <= cmp_ce;
                            illegal_reg  <= rm_illegal;
                            if (cmp_mis || cmp_ce || rm_illegal) begin
                                err_sticky_reg <= 1'b1;
                                if (!(&err_count_reg)) err_count_reg <= err_count_reg + CNT_ONE;
                            end
                            if (rm_illegal) begin
                                state_reg     <= ST_UNSYNC;
                                exp_valid_reg <= 1'b0;
                            end else begin
                                q_exp_reg <= rm_q_next;
                            end
                        end
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        exp_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q_exp      = q_exp_reg;
    assign bus.exp_valid  = exp_valid_reg;
    assign bus.mismatch   = mismatch_reg;
    assign bus.comp_err   = comp_err_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.err_sticky = err_sticky_reg;
    assign bus.err_count  = err_count_reg;
    assign bus.chk_count  = chk_count_reg;

endmodule

// File: tb/tb_ff_response_checker.sv
// Directed and randomized bench for ff_response_checker (8-bit and 2-bit counter instances in lockstep).
module tb_ff_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ff_response_checker_if #(.CNT_W(8)) bus8 ();
    ff_response_checker_if #(.CNT_W(2)) bus2 ();

    ff_response_checker #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    ff_response_checker #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus and the harness flip-flop whose outputs feed q_obs/qn_obs
    bit s_mode, s_en, s_a, s_b, s_q, s_qn;
    bit q_ff;

    // Reference expectations
    bit m_armed, m_synced, m_sync_mode, m_qexp, m_mis, m_ce, m_ill, m_sticky;
    int m_errs, m_chks;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus8.mode = s_mode; bus8.check_en = s_en; bus8.a = s_a; bus8.b = s_b;
        bus8.q_obs = s_q;   bus8.qn_obs = s_qn;
        bus2.mode = s_mode; bus2.check_en = s_en; bus2.a = s_a; bus2.b = s_b;
        bus2.q_obs = s_q;   bus2.qn_obs = s_qn;
    endtask

    // Characteristic equations: JK q+ = J~q | ~Kq ; SR q+ = S | ~Rq
    function automatic bit ff_next(bit m, bit a, bit b, bit q);
        return m ? (a | (!b & q)) : ((a & !q) | (!b & q));
    endfunction

    function automatic int sat(int v, int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_synced = 0; m_sync_mode = 0; m_qexp = 0;
        m_mis = 0; m_ce = 0; m_ill = 0; m_sticky = 0; m_errs = 0; m_chks = 0;
    endtask

    task automatic model_step();
        m_mis = 0; m_ce = 0; m_ill = 0;
        if (!s_en) begin
            m_armed = 0; m_synced = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (!m_synced) begin
            if (s_a != s_b) begin
                m_qexp = s_a; m_synced = 1; m_sync_mode = s_mode;
            end
`ifdef FF_CHK_LOCK_ON_OBS_EN
            else if ((s_q != s_qn) && !(s_mode && s_a && s_b)) begin
                m_qexp = ff_next(s_mode, s_a, s_b, s_q); m_synced = 1; m_sync_mode = s_mode;
            end
`endif
        end else if (s_mode != m_sync_mode) begin
            m_synced = 0;
        end else begin
            m_chks++;
            m_mis = (s_q != m_qexp);
            m_ce  = (s_q == s_qn);
            m_ill = s_mode && s_a && s_b;
            if (m_mis || m_ce || m_ill) begin
                m_errs++; m_sticky = 1;
            end
            if (m_ill) m_synced = 0;
            else       m_qexp = ff_next(s_mode, s_a, s_b, m_qexp);
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".q_exp"},      bus8.q_exp,      m_qexp);
        chk({tag, ".exp_valid"},  bus8.exp_valid,  m_synced);
        chk({tag, ".mismatch"},   bus8.mismatch,   m_mis);
        chk({tag, ".comp_err"},   bus8.comp_err,   m_ce);
        chk({tag, ".illegal"},    bus8.illegal,    m_ill);
        chk({tag, ".err_sticky"}, bus8.err_sticky, m_sticky);
        chk({tag, ".err_count"},  bus8.err_count,  sat(m_errs, 8));
        chk({tag, ".chk_count"},  bus8.chk_count,  sat(m_chks, 8));
        chk({tag, ".err_count2"}, bus2.err_count,  sat(m_errs, 2));
        chk({tag, ".chk_count2"}, bus2.chk_count,  sat(m_chks, 2));
    endtask

    task automatic cycle(bit en, bit m, bit a, bit b, string tag);
        s_en = en; s_mode = m; s_a = a; s_b = b;
        drive();
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
        $display("cyc %-12s en=%0b mode=%0b ab=%0b%0b q_exp=%0b valid=%0b err=%0d chk=%0d",
                 tag, en, m, a, b, bus8.q_exp, bus8.exp_valid, bus8.err_count, bus8.chk_count);
        // Harness flip-flop: SR 11 leaves the stored value alone
        if (!(m && a && b)) q_ff = ff_next(m, a, b, q_ff);
        s_q = q_ff; s_qn = !q_ff;
        drive();
    endtask

    task automatic override_obs(bit q, bit qn);
        s_q = q; s_qn = qn;
        drive();
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit jk_a [5] = '{1, 0, 1, 1, 0};
    bit jk_b [5] = '{0, 1, 1, 1, 0};
    bit jk_q [5] = '{1, 0, 1, 0, 0};
    int err_before;

    initial begin
        s_mode = 0; s_en = 0; s_a = 0; s_b = 0; q_ff = 0; s_q = 0; s_qn = 1;
        drive();
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // JK sequence against a well-behaved flop
        cycle(1, 0, 0, 0, "jk_arm");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, jk_a[i], jk_b[i], $sformatf("jk_seq%0d", i));
            chk($sformatf("jk_seq%0d.q_exp_const", i), bus8.q_exp, jk_q[i]);
            chk($sformatf("jk_seq%0d.valid_const", i), bus8.exp_valid, 1);
        end
        chk("jk.chk_count_const", bus8.chk_count, 4);
        chk("jk.err_count_const", bus8.err_count, 0);

        // One wrong Q sample right after a toggle
        cycle(1, 0, 1, 1, "jk_tog");
        override_obs(!q_ff, q_ff);
        cycle(1, 0, 0, 0, "jk_bad");
        chk("jk_bad.mismatch_const", bus8.mismatch, 1);
        chk("jk_bad.sticky_const", bus8.err_sticky, 1);
        chk("jk_bad.err_count_const", bus8.err_count, 1);
        cycle(1, 0, 0, 0, "jk_after");
        chk("jk_after.mismatch_const", bus8.mismatch, 0);

        // SR: mode switch drops sync, 11 is illegal, 01 resyncs to 0
        cycle(1, 1, 0, 0, "sr_modechg");
        chk("sr_modechg.valid_const", bus8.exp_valid, 0);
        cycle(1, 1, 1, 0, "sr_sync");
        cycle(1, 1, 0, 0, "sr_hold");
        err_before = int'(bus8.err_count);
        cycle(1, 1, 1, 1, "sr_11");
        chk("sr_11.illegal_const", bus8.illegal, 1);
        chk("sr_11.err_inc", bus8.err_count, err_before + 1);
        chk("sr_11.valid_const", bus8.exp_valid, 0);
        cycle(1, 1, 0, 1, "sr_resync");
        chk("sr_resync.valid_const", bus8.exp_valid, 1);
        chk("sr_resync.q_exp_const", bus8.q_exp, 0);

        // Q and Qn both high while model holds 0: two error kinds, one count
        cycle(1, 1, 0, 0, "sr_hold2");
        err_before = int'(bus8.err_count);
        override_obs(1, 1);
        cycle(1, 1, 0, 0, "ce");
        chk("ce.comp_err_const", bus8.comp_err, 1);
        chk("ce.mismatch_const", bus8.mismatch, 1);
        chk("ce.err_inc", bus8.err_count, err_before + 1);

        // Five more error cycles: 2-bit counter must pin at 3
        for (int i = 0; i < 5; i++) begin
            override_obs(!q_ff, q_ff);
            cycle(1, 1, 0, 0, $sformatf("sat%0d", i));
        end
        chk("sat.err_count2_const", bus2.err_count, 3);

        // Disable: back to idle with q_exp held
        cycle(0, 1, 1, 0, "disable");
        chk("disable.valid_const", bus8.exp_valid, 0);

        // Async reset in the middle of tracking
        cycle(1, 1, 0, 0, "re_arm");
        cycle(1, 1, 1, 0, "re_sync");
        do_reset("rst_mid");
        chk("rst_mid.err_count_const", bus8.err_count, 0);
        cycle(1, 0, 0, 0, "rel_arm");
`ifdef FF_CHK_LOCK_ON_OBS_EN
        q_ff = 1;
        override_obs(1, 0);
        cycle(1, 0, 0, 0, "lock");
        chk("lock.valid_const", bus8.exp_valid, 1);
        chk("lock.q_exp_const", bus8.q_exp, 1);
`else
        cycle(1, 0, 0, 0, "no_lock");
        chk("no_lock.valid_const", bus8.exp_valid, 0);
`endif

        // Randomized traffic with occasional mode flips, disables and observation faults
        for (int i = 0; i < 400; i++) begin
            bit en, a, b;
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) s_mode = !s_mode;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                override_obs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle(en, s_mode, a, b, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
